// File: rtl/led_mux_n.sv
// Multiplexed seven-segment driver with a double-buffered digit memory and frame-aligned commit.
// Optional brightness control is compiled in with LED_MUX_DIM_EN (adds the bright input).
module led_mux_n #(
  parameter  int DIGITS         = 8,
  parameter  int DIV            = 1250,
  parameter  int GUARD          = 16,
  parameter  int SEG_ACTIVE_LOW = 1,
  parameter  int EN_ACTIVE_LOW  = 1,
  localparam int AW             = (DIGITS > 2) ? $clog2(DIGITS) : 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [5:0]        wr_data,
  input  logic              commit,
`ifdef LED_MUX_DIM_EN
  input  logic [3:0]        bright,
`endif
  output logic              commit_pending,
  output logic              frame_start,
  output logic [7:0]        dataout,
  output logic [DIGITS-1:0] en
);

  localparam int CW = $clog2(DIV);
  localparam logic [5:0] BLANK = 6'b100000;

  function automatic logic [7:0] decode(input logic [5:0] d);
    logic [6:0] g;
    case (d[3:0])
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    return d[5] ? 8'h00 : {d[4], g};
  endfunction

  function automatic logic [7:0] seg_pol(input logic [7:0] s);
    return (SEG_ACTIVE_LOW != 0) ? ~s : s;
  endfunction

  function automatic logic [DIGITS-1:0] en_pol(input logic [DIGITS-1:0] e);
    return (EN_ACTIVE_LOW != 0) ? ~e : e;
  endfunction

  logic [CW-1:0]     cnt;
  logic [AW-1:0]     idx;
  logic [5:0]        staging [DIGITS];
  logic [5:0]        active  [DIGITS];
  logic              tick, wrap, copy;
  logic              lit_p0;
  logic [DIGITS-1:0] onehot_p0;
  logic [7:0]        seg_p0;

  assign tick = (cnt == CW'(DIV - 1));
  assign wrap = tick && (idx == AW'(DIGITS - 1));
  // A commit arriving on the wrap cycle itself is honoured immediately.
  assign copy = wrap && (commit_pending || commit);

`ifdef LED_MUX_DIM_EN
  logic [3:0] bright_q;
  logic [3:0] bright_eff;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)          bright_q <= 4'hF;
    else if (cnt == '0) bright_q <= bright;
  end

  assign bright_eff = (cnt == '0) ? bright : bright_q;

  always_comb begin
    lit_p0 = 1'b0;
    if (int'(cnt) >= GUARD)
      lit_p0 = ((int'(cnt) - GUARD) * 16) < ((DIV - GUARD) * (int'(bright_eff) + 1));
  end
`else
  assign lit_p0 = (int'(cnt) >= GUARD);
`endif

  assign onehot_p0 = {{(DIGITS-1){1'b0}}, 1'b1} << idx;
  assign seg_p0    = decode(active[idx]);

  // Scan prescaler and digit index.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= (idx == AW'(DIGITS - 1)) ? '0 : idx + AW'(1);
    end
  end

  // Digit memories: the copy reads pre-write staging because both update on the same edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DIGITS; i++) begin
        staging[i] <= BLANK;
        active[i]  <= BLANK;
      end
    end else begin
      if (wr_en && (32'(wr_addr) < DIGITS)) staging[wr_addr] <= wr_data;
      if (copy)
        for (int i = 0; i < DIGITS; i++) active[i] <= staging[i];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      commit_pending <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (wrap)        commit_pending <= 1'b0;
      else if (commit) commit_pending <= 1'b1;
    end
  end

  // Output stage: one cycle behind cnt/idx, polarity applied last.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      en      <= en_pol('0);
      dataout <= seg_pol(8'h00);
    end else begin
      en      <= en_pol(lit_p0 ? onehot_p0 : '0);
      dataout <= seg_pol(seg_p0);
    end
  end

endmodule

// File: tb/tb_led_mux_n.sv
// Directed bench for led_mux_n: DIGITS=4, DIV=8, GUARD=2, active-low segments and enables.
module tb_led_mux_n;

  logic       clk = 1'b0;
  logic       nrst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [5:0] wr_data;
  logic       commit;
  logic       commit_pending;
  logic       frame_start;
  logic [7:0] dataout;
  logic [3:0] en;
`ifdef LED_MUX_DIM_EN
  logic [3:0] bright = 4'hF;
`endif

  int checks = 0;
  int errors = 0;
  int k = 0;

  led_mux_n #(
    .DIGITS(4), .DIV(8), .GUARD(2), .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .commit(commit),
`ifdef LED_MUX_DIM_EN
    .bright(bright),
`endif
    .commit_pending(commit_pending),
    .frame_start(frame_start),
    .dataout(dataout),
    .en(en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // k counts rising edges since reset release; sampling happens on the falling edge.
  task automatic cyc();
    @(negedge clk);
    k++;
  endtask

  task automatic wr(input logic [1:0] a, input logic [5:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  // Outputs after edge k reflect the scan state of edge k-1: cnt=(k-1)%8, idx=((k-1)/8)%4.
  task automatic run_to(input int kend, input logic [7:0] t0, input logic [7:0] t1,
                        input logic [7:0] t2, input logic [7:0] t3, input logic pend);
    logic [7:0] tab [4];
    logic [3:0] e;
    int c, i;
    tab[0] = t0; tab[1] = t1; tab[2] = t2; tab[3] = t3;
    while (k < kend) begin
      cyc();
      c = (k - 1) % 8;
      i = ((k - 1) / 8) % 4;
      e = 4'hF;
      if (c >= 2) e[i] = 1'b0;
      check("en", 32'(en), 32'(e));
      check("dataout", 32'(dataout), 32'(tab[i]));
      check("frame_start", 32'(frame_start), 32'((k % 32) == 0));
      check("pending", 32'(commit_pending), 32'(pend));
    end
  endtask

  initial begin
    nrst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en", 32'(en), 32'h0000000F);
    check("rst_dataout", 32'(dataout), 32'h000000FF);
    check("rst_pending", 32'(commit_pending), 32'h0);
    check("rst_frame_start", 32'(frame_start), 32'h0);
    nrst = 1'b1;
    k = 0;

    // Blank frame after reset, scan cycles through all digits.
    run_to(32, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);

    // Write "3.14" and commit mid-frame.
    wr(2'd0, 6'h13); wr(2'd1, 6'h01); wr(2'd2, 6'h04); wr(2'd3, 6'h20);
    commit = 1'b1; cyc(); commit = 1'b0;
    check("pend_set", 32'(commit_pending), 32'h1);
    run_to(63, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    cyc();
    check("wrap_pending", 32'(commit_pending), 32'h0);
    check("wrap_frame_start", 32'(frame_start), 32'h1);
    check("wrap_dataout", 32'(dataout), 32'h000000FF);
    run_to(96, 8'h30, 8'hF9, 8'h99, 8'hFF, 1'b0);

    // Staging write without commit leaves the display untouched for several frames.
    wr(2'd0, 6'h0F);
    run_to(223, 8'h30, 8'hF9, 8'h99, 8'hFF, 1'b0);

    // Commit plus write on the wrap-tick cycle: copy uses pre-write staging.
    commit = 1'b1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 6'h02;
    cyc();
    commit = 1'b0; wr_en = 1'b0;
    check("tick_commit_pending", 32'(commit_pending), 32'h0);
    check("tick_commit_frame_start", 32'(frame_start), 32'h1);
    run_to(256, 8'h8E, 8'hF9, 8'h99, 8'hFF, 1'b0);

    // The write from the wrap cycle shows only after another commit.
    commit = 1'b1; cyc(); commit = 1'b0;
    check("pend_set2", 32'(commit_pending), 32'h1);
    run_to(287, 8'h8E, 8'hF9, 8'h99, 8'hFF, 1'b1);
    cyc();
    check("wrap_pending2", 32'(commit_pending), 32'h0);
    check("wrap_frame_start2", 32'(frame_start), 32'h1);
    run_to(320, 8'h8E, 8'hA4, 8'h99, 8'hFF, 1'b0);

    // Asynchronous reset mid-slot with a commit pending.
    commit = 1'b1; cyc(); commit = 1'b0;
    cyc(); cyc();
    check("pre_rst_pending", 32'(commit_pending), 32'h1);
    check("pre_rst_en", 32'(en), 32'h0000000E);
    #2 nrst = 1'b0;
    #1;
    check("async_rst_en", 32'(en), 32'h0000000F);
    check("async_rst_dataout", 32'(dataout), 32'h000000FF);
    check("async_rst_pending", 32'(commit_pending), 32'h0);
    check("async_rst_frame_start", 32'(frame_start), 32'h0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    k = 0;
    run_to(64, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
